// File: rtl/pipe_slice_chain_pkg.sv
// Shared helpers for the pipe_slice_chain family: ceiling log2 and the
// occupancy-counter width derived from the chain depth.
package pipe_slice_chain_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  // The counter must hold 0..depth; a zero-depth chain still gets a 1-bit port.
  function automatic int occ_width(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slice_chain_slot.sv
// One stage of the chain: a data register plus its valid flop, with async
// reset, synchronous clear and a load enable driven by the ready chain.
module pipe_slot #(
  parameter int               WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the chain shifts by one.
  // NOTE: the data register is reset as well as the valid bit, so out_data
  // shows RESET_VALUE immediately on rst or after sclr, not stale payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_out <= 1'b0;
      d_out <= RESET_VALUE;
    end else if (sclr) begin
      v_out <= 1'b0;
      d_out <= RESET_VALUE;
    end else if (load) begin
      v_out <= v_in;
      d_out <= d_in;
    end
  end

endmodule

// File: rtl/pipe_slice_chain.sv
// Stallable register chain with valid/ready backpressure, clock enable,
// synchronous clear, bubble collapse and a registered occupancy count.
module pipe_slice_chain
  import pipe_slice_chain_pkg::*;
#(
  parameter int               WIDTH       = 18,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          sclr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occ_count
);

  localparam int CW = occ_width(DEPTH);

  if (DEPTH == 0) begin : g_pass
    assign in_ready  = out_ready & ce & ~sclr;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign occ_count = '0;
  end else begin : g_chain
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] move;
    logic [WIDTH-1:0] d [DEPTH];
    logic             accept;
    logic             emit;

    // A stage may advance if it is empty or its successor advances; this is
    // what lets bubbles collapse while the output is stalled.
    always_comb begin
      move            = '0;
      move[DEPTH-1]   = ~v[DEPTH-1] | out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
        move[i] = ~v[i] | move[i+1];
      end
    end

    assign in_ready = ce & ~sclr & move[0];
    assign accept   = in_valid & in_ready;
    assign emit     = v[DEPTH-1] & out_ready & ce & ~sclr;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [WIDTH-1:0] src_d;
      logic             src_v;

      if (i == 0) begin : g_head
        assign src_d = in_data;
        assign src_v = accept;
      end else begin : g_body
        assign src_d = d[i-1];
        assign src_v = v[i-1];
      end

      pipe_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .sclr  (sclr),
        .load  (ce & move[i]),
        .d_in  (src_d),
        .v_in  (src_v),
        .d_out (d[i]),
        .v_out (v[i])
      );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    // Tracks popcount(v) incrementally; accept and emit together cancel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        occ_count <= '0;
      end else if (sclr) begin
        occ_count <= '0;
      end else if (accept && !emit) begin
        occ_count <= occ_count + CW'(1);
      end else if (emit && !accept) begin
        occ_count <= occ_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_slice_chain.sv
// Directed bench for pipe_slice_chain: a DEPTH=3 vector table plus
// hand-written sequences for reset, bubble collapse (DEPTH=4) and DEPTH=0.
module tb_pipe_slice_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=3 instance, non-zero reset value so clears are observable
  logic       rst, ce, sclr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] occ_count;

  pipe_slice_chain #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h5A)) u3 (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ_count(occ_count)
  );

  // DEPTH=4 instance for the bubble-collapse sequence
  logic       r4_rst, r4_ce, r4_sclr, r4_in_valid, r4_in_ready, r4_out_valid, r4_out_ready;
  logic [7:0] r4_in_data, r4_out_data;
  logic [2:0] r4_occ;

  pipe_slice_chain #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u4 (
    .clk(clk), .rst(r4_rst), .ce(r4_ce), .sclr(r4_sclr),
    .in_valid(r4_in_valid), .in_ready(r4_in_ready), .in_data(r4_in_data),
    .out_valid(r4_out_valid), .out_ready(r4_out_ready), .out_data(r4_out_data),
    .occ_count(r4_occ)
  );

  // DEPTH=0 pass-through instance
  logic       z_rst, z_ce, z_sclr, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [7:0] z_in_data, z_out_data;
  logic [0:0] z_occ;

  pipe_slice_chain #(.WIDTH(8), .DEPTH(0), .RESET_VALUE(8'h00)) u0 (
    .clk(clk), .rst(z_rst), .ce(z_ce), .sclr(z_sclr),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .occ_count(z_occ)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One row: inputs applied for a cycle, in_ready expected before the edge,
  // outputs expected after it.
  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ce;
    logic       sclr;
    logic       x_ir;
    logic       x_ov;
    logic       x_chk_d;
    logic [7:0] x_od;
    logic [1:0] x_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic c, input logic s, input logic ir, input logic ov,
                              input logic chk, input logic [7:0] od, input logic [1:0] occ);
    vec_t r;
    r.iv = iv; r.id = id; r.ordy = ordy; r.ce = c; r.sclr = s;
    r.x_ir = ir; r.x_ov = ov; r.x_chk_d = chk; r.x_od = od; r.x_occ = occ;
    return r;
  endfunction

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ce;
    logic       sclr;
    logic       x_ir;
  } zvec_t;

  zvec_t ztbl[4];

  initial begin
    // streaming, out_ready=1: each word appears 3 cycles after being driven
    tbl.push_back(mk(1, 8'h11, 1, 1, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 8'h22, 1, 1, 0, 1, 0, 0, 8'h00, 2));
    tbl.push_back(mk(1, 8'h33, 1, 1, 0, 1, 1, 1, 8'h11, 3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 1, 8'h22, 2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 1, 8'h33, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 0));
    // backpressure: fill to full, A4 refused, then drain in order
    tbl.push_back(mk(1, 8'hA1, 0, 1, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 8'hA2, 0, 1, 0, 1, 0, 0, 8'h00, 2));
    tbl.push_back(mk(1, 8'hA3, 0, 1, 0, 1, 1, 1, 8'hA1, 3));
    tbl.push_back(mk(1, 8'hA4, 0, 1, 0, 0, 1, 1, 8'hA1, 3));
    tbl.push_back(mk(1, 8'hA4, 0, 1, 0, 0, 1, 1, 8'hA1, 3));
    tbl.push_back(mk(1, 8'hA4, 1, 1, 0, 1, 1, 1, 8'hA2, 3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 1, 8'hA3, 2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 1, 8'hA4, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 0));
    // clock-enable freeze for 5 cycles mid-stream
    tbl.push_back(mk(1, 8'hB1, 1, 1, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 8'hB2, 1, 1, 0, 1, 0, 0, 8'h00, 2));
    tbl.push_back(mk(1, 8'hB3, 1, 1, 0, 1, 1, 1, 8'hB1, 3));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 8'hB4, 1, 0, 0, 0, 1, 1, 8'hB1, 3));
    tbl.push_back(mk(1, 8'hB4, 1, 1, 0, 1, 1, 1, 8'hB2, 3));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 1, 8'hB3, 2));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 1, 1, 8'hB4, 1));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 0));
    // synchronous clear with a full chain and a word on the input
    tbl.push_back(mk(1, 8'hC1, 0, 1, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 8'hC2, 0, 1, 0, 1, 0, 0, 8'h00, 2));
    tbl.push_back(mk(1, 8'hC3, 0, 1, 0, 1, 1, 1, 8'hC1, 3));
    tbl.push_back(mk(1, 8'hC4, 1, 1, 1, 0, 0, 1, 8'h5A, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 0));
    // sclr also acts while ce=0
    tbl.push_back(mk(1, 8'hC5, 0, 1, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 8'hC6, 0, 0, 1, 0, 0, 1, 8'h5A, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00, 0));

    ztbl[0] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1};
    ztbl[1] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};
    ztbl[2] = '{1'b0, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0};
    ztbl[3] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    r4_rst = 1'b1; r4_ce = 1'b1; r4_sclr = 1'b0; r4_in_valid = 1'b0; r4_in_data = 8'h00;
    r4_out_ready = 1'b0;
    z_rst = 1'b0; z_ce = 1'b1; z_sclr = 1'b0; z_in_valid = 1'b0; z_in_data = 8'h00;
    z_out_ready = 1'b0;

    #1;
    check("rst out_valid async", 32'(out_valid), 32'd0);
    check("rst out_data async", 32'(out_data), 32'h5A);
    tick; tick;
    rst = 1'b0; r4_rst = 1'b0;
    #1;
    check("reset occ", 32'(occ_count), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'h5A);
    check("reset in_ready", 32'(in_ready), 32'd1);
    tick;

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
      ce = tbl[i].ce; sclr = tbl[i].sclr;
      #1;
      check($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].x_ir));
      tick;
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].x_ov));
      check($sformatf("row%0d occ", i), 32'(occ_count), 32'(tbl[i].x_occ));
      if (tbl[i].x_chk_d)
        check($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].x_od));
    end

    // asynchronous reset between edges with a full chain
    ce = 1'b1; sclr = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'hD1 + 8'(i);
      tick;
    end
    in_valid = 1'b0;
    #1;
    check("full occ", 32'(occ_count), 32'd3);
    check("full in_ready", 32'(in_ready), 32'd0);
    check("full out_data", 32'(out_data), 32'hD1);
    rst = 1'b1;
    #1;
    check("mid-cycle rst out_valid", 32'(out_valid), 32'd0);
    check("mid-cycle rst occ", 32'(occ_count), 32'd0);
    check("mid-cycle rst out_data", 32'(out_data), 32'h5A);
    tick;
    rst = 1'b0;
    #1;
    check("post rst in_ready", 32'(in_ready), 32'd1);

    // DEPTH=4 bubble collapse: 0x01, bubble, 0x02 with output stalled
    r4_in_valid = 1'b1; r4_in_data = 8'h01; tick;
    r4_in_valid = 1'b0; r4_in_data = 8'h00; tick;
    r4_in_valid = 1'b1; r4_in_data = 8'h02; tick;
    r4_in_valid = 1'b0; r4_in_data = 8'h00;
    for (int i = 0; i < 4; i++) tick;
    check("bubble occ", 32'(r4_occ), 32'd2);
    check("bubble out_valid", 32'(r4_out_valid), 32'd1);
    check("bubble out_data", 32'(r4_out_data), 32'h01);
    check("bubble in_ready", 32'(r4_in_ready), 32'd1);
    r4_out_ready = 1'b1;
    tick;
    check("bubble 2nd word adjacent", 32'(r4_out_data), 32'h02);
    check("bubble 2nd valid", 32'(r4_out_valid), 32'd1);
    check("bubble occ after emit", 32'(r4_occ), 32'd1);
    tick;
    check("bubble drained valid", 32'(r4_out_valid), 32'd0);
    check("bubble drained occ", 32'(r4_occ), 32'd0);

    // DEPTH=0 combinational pass-through
    foreach (ztbl[i]) begin
      z_in_valid = ztbl[i].iv; z_in_data = ztbl[i].id; z_out_ready = ztbl[i].ordy;
      z_ce = ztbl[i].ce; z_sclr = ztbl[i].sclr;
      #1;
      check($sformatf("pass%0d out_data", i), 32'(z_out_data), 32'(ztbl[i].id));
      check($sformatf("pass%0d out_valid", i), 32'(z_out_valid), 32'(ztbl[i].iv));
      check($sformatf("pass%0d in_ready", i), 32'(z_in_ready), 32'(ztbl[i].x_ir));
      check($sformatf("pass%0d occ", i), 32'(z_occ), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
